// File: rtl/ysyx_201979054_axi_pkg.sv
// Shared AXI4 encodings and FSM state type for the burst master.
package ysyx_201979054_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } axi_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [2:0] AXI_SIZE_32    = 3'd2;

    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/ysyx_201979054_beat_counter.sv
// Beat index within a burst with terminal-count compare against AXI len.
module ysyx_201979054_beat_counter
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [7:0]       i_len,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (8'(r_cnt) == i_len);

endmodule

// File: rtl/ysyx_201979054_axi4_burst_master.sv
// AXI4 master: one INCR cache-block burst or one non-cacheable beat per start pulse.
module ysyx_201979054_axi4_burst_master
    import ysyx_201979054_axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           i_start_read,
    input  logic                           i_start_write,
    input  logic                           i_nc,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic [DATA_W-1:0]              i_wdata,
    input  logic [DATA_W/8-1:0]            i_wstrb,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_beat_cnt,
    output logic [DATA_W-1:0]              o_rdata,
    output logic                           o_rdata_we,
    output logic                           o_read_last,
    output logic                           o_b_resp,
    output logic                           o_error,
    output logic [ADDR_W-1:0]              o_araddr,
    output logic [7:0]                     o_arlen,
    output logic [2:0]                     o_arsize,
    output logic [1:0]                     o_arburst,
    output logic                           o_arvalid,
    input  logic                           i_arready,
    input  logic [DATA_W-1:0]              i_rdata,
    input  logic [1:0]                     i_rresp,
    input  logic                           i_rlast,
    input  logic                           i_rvalid,
    output logic                           o_rready,
    output logic [ADDR_W-1:0]              o_awaddr,
    output logic [7:0]                     o_awlen,
    output logic [2:0]                     o_awsize,
    output logic [1:0]                     o_awburst,
    output logic                           o_awvalid,
    input  logic                           i_awready,
    output logic [DATA_W-1:0]              o_wdata,
    output logic [DATA_W/8-1:0]            o_wstrb,
    output logic                           o_wlast,
    output logic                           o_wvalid,
    input  logic                           i_wready,
    input  logic [1:0]                     i_bresp,
    input  logic                           i_bvalid,
    output logic                           o_bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK =
        ~ADDR_W'(BLOCK_WORDS * STRB_W - 1);

    axi_state_t r_state;
    axi_state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [STRB_W-1:0] r_strb;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_we;
    logic              r_read_last;
    logic              r_b_resp;
    logic              r_error;

    logic w_start;
    logic w_start_wr;
    logic w_r_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_tc;
    logic w_cnt_en;
    logic w_cnt_clr;
    logic w_arvalid;
    logic w_rready;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_resp_err;

    assign w_start    = (r_state == S_IDLE) & (i_start_read | i_start_write);
    assign w_start_wr = (r_state == S_IDLE) & i_start_write;
    assign w_r_hs     = w_rready & i_rvalid;
    assign w_w_hs     = w_wvalid & i_wready;
    assign w_b_hs     = w_bready & i_bvalid;
    assign w_cnt_en   = w_r_hs | w_w_hs;
    assign w_cnt_clr  = (w_r_hs & i_rlast) | (w_w_hs & w_tc);

    ysyx_201979054_beat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .arst  (arst),
        .i_en  (w_cnt_en),
        .i_clr (w_cnt_clr),
        .i_len (r_len),
        .o_cnt (o_beat_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Write wins a same-cycle collision; valids are pure state decodes.
    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start_write) begin
                    w_next = S_AW;
                end else if (i_start_read) begin
                    w_next = S_AR;
                end
            end
            S_AR: begin
                w_arvalid = 1'b1;
                if (i_arready) w_next = S_R;
            end
            S_R: begin
                w_rready = 1'b1;
                if (i_rvalid && i_rlast) w_next = S_IDLE;
            end
            S_AW: begin
                w_awvalid = 1'b1;
                if (i_awready) w_next = S_W;
            end
            S_W: begin
                w_wvalid = 1'b1;
                if (i_wready && w_tc) w_next = S_B;
            end
            S_B: begin
                w_bready = 1'b1;
                if (i_bvalid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_resp_err = (w_r_hs & ((i_rresp != RESP_OKAY) | (i_rlast & ~w_tc)))
                      | (w_b_hs & (i_bresp != RESP_OKAY));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_strb      <= '0;
            r_rdata     <= '0;
            r_rdata_we  <= 1'b0;
            r_read_last <= 1'b0;
            r_b_resp    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rdata_we  <= w_r_hs;
            r_read_last <= w_r_hs & i_rlast;
            r_b_resp    <= w_b_hs;
            if (w_r_hs) r_rdata <= i_rdata;
            if (w_start) begin
                r_addr <= i_nc ? i_addr : (i_addr & BLK_MASK);
                r_len  <= i_nc ? 8'd0 : 8'(BLOCK_WORDS - 1);
                r_strb <= (w_start_wr & i_nc) ? i_wstrb : '1;
            end
            if (w_start) begin
                r_error <= 1'b0;
            end else if (w_resp_err) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_araddr    = r_addr;
    assign o_arlen     = r_len;
    assign o_arsize    = axi_size(STRB_W);
    assign o_arburst   = AXI_BURST_INCR;
    assign o_arvalid   = w_arvalid;
    assign o_rready    = w_rready;
    assign o_awaddr    = r_addr;
    assign o_awlen     = r_len;
    assign o_awsize    = axi_size(STRB_W);
    assign o_awburst   = AXI_BURST_INCR;
    assign o_awvalid   = w_awvalid;
    assign o_wvalid    = w_wvalid;
    assign o_wdata     = w_wvalid ? i_wdata : '0;
    assign o_wstrb     = w_wvalid ? r_strb : '0;
    assign o_wlast     = w_wvalid & w_tc;
    assign o_bready    = w_bready;
    assign o_rdata     = r_rdata;
    assign o_rdata_we  = r_rdata_we;
    assign o_read_last = r_read_last;
    assign o_b_resp    = r_b_resp;
    assign o_error     = r_error;

endmodule
